// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the sequenced 1-to-N demultiplexer:
//   mode_e  - operating mode encoding driven on the mode input
//   clog2   - ceiling log2, used to size the select and channel-index fields
// -----------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,  // route din to the selected channel, others zero
        MODE_SCAN   = 2'b01,  // step the active channel on every prescaler tick
        MODE_LATCH  = 2'b10,  // sticky register bank, write one channel at a time
        MODE_HOLD   = 2'b11   // freeze all outputs
    } mode_e;

    // Number of bits needed to index 'value' distinct items (value >= 2).
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/demux1_n_seq_if.sv
// -----------------------------------------------------------------------------
// demux1_n_seq_if
// Bundles the control/data signals of demux1_n_seq.
//   en    enable (meaning depends on mode)
//   mode  operating mode (demux_pkg::mode_e)
//   sel   channel select / scan start channel, SW_W bits
//   din   data to route, DW bits
//   div   scan period minus one, DIV_W bits
//   dout  N_CH*DW registered channel bank, channel k at [k*DW +: DW]
//   ch    registered active channel index
//   tick  registered one-cycle pulse on each scan step
// Modports: master drives the controls and observes the outputs, slave is the
// demultiplexer itself.
// -----------------------------------------------------------------------------
interface demux1_n_seq_if
    import demux_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int DW    = 1,
    parameter int DIV_W = 26
);

    localparam int SW_W = clog2(N_CH);

    logic                 en;
    mode_e                mode;
    logic [SW_W-1:0]      sel;
    logic [DW-1:0]        din;
    logic [DIV_W-1:0]     div;
    logic [N_CH*DW-1:0]   dout;
    logic [SW_W-1:0]      ch;
    logic                 tick;

    modport master (
        output en, mode, sel, din, div,
        input  dout, ch, tick
    );

    modport slave (
        input  en, mode, sel, din, div,
        output dout, ch, tick
    );

endinterface

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Scan-rate prescaler. The counter runs 0..div while 'run' is high; in the
// cycle it sits at (or above) div it wraps to zero and raises 'tick' for that
// cycle. 'clr' restarts the count and suppresses the tick.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears the count
//   run    count enable
//   clr    synchronous restart, has priority over run
//   div    terminal count (period minus one)
//   tick   combinational terminal-count strobe; the owner registers it
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             terminal;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        cnt_d    = cnt_q;
        tick     = 1'b0;
        // '>=' rather than '==': if div is lowered below the running count the
        // next enabled cycle is treated as terminal instead of counting to wrap.
        terminal = (cnt_q >= div);
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (terminal) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux1_n_seq.sv
// -----------------------------------------------------------------------------
// demux1_n_seq
// Registered 1-to-N_CH demultiplexer with four modes:
//   DIRECT  din to channel sel, zeros elsewhere; ch follows sel
//   SCAN    din to channel ch, ch advances on each prescaler tick (wraps)
//   LATCH   din written into channel sel, other channels hold
//   HOLD    everything holds
// All outputs are registered, one clock of latency from the inputs.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset (dout, ch, tick, prescaler -> 0)
//   bus    demux1_n_seq_if.slave: en, mode, sel, din, div in; dout, ch, tick out
// -----------------------------------------------------------------------------
module demux1_n_seq
    import demux_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int DW    = 1,
    parameter int DIV_W = 26
) (
    input  logic           clk,
    input  logic           rst_n,
    demux1_n_seq_if.slave  bus
);

    localparam int SW_W   = clog2(N_CH);
    localparam int DOUT_W = N_CH * DW;

    logic [DOUT_W-1:0] dout_q;
    logic [DOUT_W-1:0] dout_d;
    logic [SW_W-1:0]   ch_q;
    logic [SW_W-1:0]   ch_d;
    logic              tick_q;
    logic              tick_d;
    logic              scan_q;   // previous cycle was SCAN
    logic              scan_d;

    logic              sel_ok;   // sel names an existing channel
    logic              entering; // first cycle of SCAN after another mode
    logic              run;
    logic              step;     // prescaler terminal count this cycle
    logic [SW_W-1:0]   ch_inc;

    // Returns 'base' with channel 'idx' replaced by 'data'. An index with no
    // matching channel leaves 'base' untouched.
    function automatic logic [DOUT_W-1:0] place(input logic [DOUT_W-1:0] base,
                                                input logic [SW_W-1:0]   idx,
                                                input logic [DW-1:0]     data);
        logic [DOUT_W-1:0] res;
        res = base;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SW_W'(k)) begin
                res[k*DW +: DW] = data;
            end
        end
        return res;
    endfunction

    assign sel_ok   = (32'(bus.sel) < 32'(N_CH));
    assign entering = (bus.mode == MODE_SCAN) && !scan_q;
    assign run      = (bus.mode == MODE_SCAN) && bus.en;
    assign ch_inc   = (ch_q == SW_W'(N_CH - 1)) ? '0 : ch_q + SW_W'(1);

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .clr   (entering),
        .div   (bus.div),
        .tick  (step)
    );

    always_comb begin
        dout_d = dout_q;
        ch_d   = ch_q;
        tick_d = 1'b0;
        scan_d = (bus.mode == MODE_SCAN);

        unique case (bus.mode)
            MODE_DIRECT: begin
                dout_d = '0;
                // An out-of-range select has no channel to report, so ch holds.
                if (bus.en && sel_ok) begin
                    dout_d = place('0, bus.sel, bus.din);
                    ch_d   = bus.sel;
                end
            end

            MODE_SCAN: begin
                if (entering) begin
                    ch_d = sel_ok ? bus.sel : '0;
                end else if (step) begin
                    ch_d   = ch_inc;
                    tick_d = 1'b1;
                end
                // Data follows the post-update channel so dout and ch agree.
                dout_d = bus.en ? place('0, ch_d, bus.din) : '0;
            end

            MODE_LATCH: begin
                // dout_q is the bank, so entering LATCH keeps whatever DIRECT
                // or SCAN left there.
                if (bus.en && sel_ok) begin
                    dout_d = place(dout_q, bus.sel, bus.din);
                end
            end

            default: begin
                // MODE_HOLD: all defaults hold, tick stays low.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            ch_q   <= '0;
            tick_q <= 1'b0;
            // Reset counts as "already scanning": if mode is SCAN when reset
            // releases, scanning resumes from ch=0 instead of reloading sel.
            scan_q <= 1'b1;
        end else begin
            dout_q <= dout_d;
            ch_q   <= ch_d;
            tick_q <= tick_d;
            scan_q <= scan_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.ch   = ch_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_demux1_n_seq.sv
// -----------------------------------------------------------------------------
// tb_demux1_n_seq
// Two instances: A (N_CH=16, DW=1) and B (N_CH=10, DW=4, non-power-of-two).
// Table of directed vectors on A, hand sequences for latch, out-of-range
// select, lowered divisor and mid-scan reset, then random stimulus on both
// against a channel-array reference model.
// -----------------------------------------------------------------------------
module tb_demux1_n_seq;
    import demux_pkg::*;

    localparam int A_N   = 16;
    localparam int A_DW  = 1;
    localparam int B_N   = 10;
    localparam int B_DW  = 4;
    localparam int DIV_W = 26;
    localparam int SW_W  = 4;  // clog2 of both 16 and 10

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    demux1_n_seq_if #(.N_CH(A_N), .DW(A_DW), .DIV_W(DIV_W)) bus_a ();
    demux1_n_seq_if #(.N_CH(B_N), .DW(B_DW), .DIV_W(DIV_W)) bus_b ();

    demux1_n_seq #(.N_CH(A_N), .DW(A_DW), .DIV_W(DIV_W)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    demux1_n_seq #(.N_CH(B_N), .DW(B_DW), .DIV_W(DIV_W)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance, the value held by each channel, the
    // active channel, a cycle counter within the scan period, and whether the
    // previous cycle was in SCAN.
    int m_data [2][64];
    int m_ch   [2];
    int m_cnt  [2];
    bit m_scan [2];
    bit m_tick [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 64; k++) m_data[d][k] = 0;
            m_ch[d]   = 0;
            m_cnt[d]  = 0;
            m_scan[d] = 1'b1;
            m_tick[d] = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input int n, input bit en, input mode_e mode,
                              input int sel, input int din, input int div);
        bit entering;
        entering  = (mode == MODE_SCAN) && !m_scan[d];
        m_tick[d] = 1'b0;
        case (mode)
            MODE_DIRECT: begin
                for (int k = 0; k < n; k++) m_data[d][k] = 0;
                if (en && sel < n) begin
                    m_data[d][sel] = din;
                    m_ch[d]        = sel;
                end
            end
            MODE_SCAN: begin
                if (entering) begin
                    m_cnt[d] = 0;
                    m_ch[d]  = (sel < n) ? sel : 0;
                end else if (en) begin
                    // Period is div+1 enabled cycles; a count already past a
                    // lowered div ends the period immediately.
                    if (m_cnt[d] >= div) begin
                        m_cnt[d]  = 0;
                        m_tick[d] = 1'b1;
                        m_ch[d]   = (m_ch[d] + 1) % n;
                    end else begin
                        m_cnt[d] = m_cnt[d] + 1;
                    end
                end
                for (int k = 0; k < n; k++) m_data[d][k] = 0;
                if (en) m_data[d][m_ch[d]] = din;
            end
            MODE_LATCH: begin
                if (en && sel < n) m_data[d][sel] = din;
            end
            default: ;
        endcase
        m_scan[d] = (mode == MODE_SCAN);
    endtask

    function automatic logic [63:0] model_dout(input int d, input int n, input int dw);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r = r | (64'(m_data[d][k]) << (k * dw));
        return r;
    endfunction

    task automatic compare_model(input string tag);
        check({tag, "_a_dout"}, 64'(bus_a.dout), model_dout(0, A_N, A_DW));
        check({tag, "_a_ch"},   64'(bus_a.ch),   64'(m_ch[0]));
        check({tag, "_a_tick"}, 64'(bus_a.tick), 64'(m_tick[0]));
        check({tag, "_b_dout"}, 64'(bus_b.dout), model_dout(1, B_N, B_DW));
        check({tag, "_b_ch"},   64'(bus_b.ch),   64'(m_ch[1]));
        check({tag, "_b_tick"}, 64'(bus_b.tick), 64'(m_tick[1]));
    endtask

    // One clock: the model consumes the inputs present at the rising edge,
    // outputs are then sampled on the falling edge.
    task automatic tick_cycle();
        @(posedge clk);
        model_step(0, A_N, bus_a.en, bus_a.mode, int'(bus_a.sel), int'(bus_a.din), int'(bus_a.div));
        model_step(1, B_N, bus_b.en, bus_b.mode, int'(bus_b.sel), int'(bus_b.din), int'(bus_b.div));
        @(negedge clk);
    endtask

    task automatic drive_a(input mode_e m, input bit en, input int sel, input int din, input int div);
        bus_a.mode = m;
        bus_a.en   = en;
        bus_a.sel  = SW_W'(sel);
        bus_a.din  = A_DW'(din);
        bus_a.div  = DIV_W'(div);
    endtask

    task automatic drive_b(input mode_e m, input bit en, input int sel, input int din, input int div);
        bus_b.mode = m;
        bus_b.en   = en;
        bus_b.sel  = SW_W'(sel);
        bus_b.din  = B_DW'(din);
        bus_b.div  = DIV_W'(div);
    endtask

    typedef struct {
        mode_e       mode;
        bit          en;
        int          sel;
        int          din;
        int          div;
        logic [63:0] exp_dout;
        int          exp_ch;
        bit          exp_tick;
    } vec_t;

    vec_t vecs [22];

    initial begin
        // DIRECT basics
        vecs[0]  = '{MODE_DIRECT, 1'b1,  5, 1, 0, 64'h0020,  5, 1'b0};
        vecs[1]  = '{MODE_DIRECT, 1'b0,  5, 1, 0, 64'h0000,  5, 1'b0};
        vecs[2]  = '{MODE_DIRECT, 1'b1,  0, 0, 0, 64'h0000,  0, 1'b0};
        vecs[3]  = '{MODE_DIRECT, 1'b1, 15, 1, 0, 64'h8000, 15, 1'b0};
        // SCAN div=2 from 14: entry, then a tick every third cycle, wrapping
        vecs[4]  = '{MODE_SCAN,   1'b1, 14, 1, 2, 64'h4000, 14, 1'b0};
        vecs[5]  = '{MODE_SCAN,   1'b1, 14, 1, 2, 64'h4000, 14, 1'b0};
        vecs[6]  = '{MODE_SCAN,   1'b1, 14, 1, 2, 64'h4000, 14, 1'b0};
        vecs[7]  = '{MODE_SCAN,   1'b1, 14, 1, 2, 64'h8000, 15, 1'b1};
        vecs[8]  = '{MODE_SCAN,   1'b1, 14, 1, 2, 64'h8000, 15, 1'b0};
        vecs[9]  = '{MODE_SCAN,   1'b1, 14, 1, 2, 64'h8000, 15, 1'b0};
        vecs[10] = '{MODE_SCAN,   1'b1, 14, 1, 2, 64'h0001,  0, 1'b1};
        vecs[11] = '{MODE_SCAN,   1'b1, 14, 1, 2, 64'h0001,  0, 1'b0};
        vecs[12] = '{MODE_SCAN,   1'b1, 14, 1, 2, 64'h0001,  0, 1'b0};
        vecs[13] = '{MODE_SCAN,   1'b1, 14, 1, 2, 64'h0002,  1, 1'b1};
        // SCAN disabled: zero data, channel and prescaler frozen
        vecs[14] = '{MODE_SCAN,   1'b0, 14, 1, 2, 64'h0000,  1, 1'b0};
        vecs[15] = '{MODE_SCAN,   1'b1, 14, 1, 2, 64'h0002,  1, 1'b0};
        // LATCH keeps the SCAN contents, then sticky writes
        vecs[16] = '{MODE_LATCH,  1'b0, 14, 1, 2, 64'h0002,  1, 1'b0};
        vecs[17] = '{MODE_LATCH,  1'b1,  9, 1, 2, 64'h0202,  1, 1'b0};
        vecs[18] = '{MODE_LATCH,  1'b1,  1, 0, 2, 64'h0200,  1, 1'b0};
        // HOLD ignores en; re-entering SCAN reloads sel
        vecs[19] = '{MODE_HOLD,   1'b1,  3, 1, 2, 64'h0200,  1, 1'b0};
        vecs[20] = '{MODE_SCAN,   1'b1,  3, 1, 2, 64'h0008,  3, 1'b0};
        vecs[21] = '{MODE_DIRECT, 1'b1,  5, 1, 2, 64'h0020,  5, 1'b0};

        drive_a(MODE_HOLD, 1'b0, 0, 0, 0);
        drive_b(MODE_HOLD, 1'b0, 0, 0, 0);
        model_reset();

        // Reset state, asserted before any clock edge
        #1;
        check("reset_a_dout", 64'(bus_a.dout), 64'h0);
        check("reset_a_ch",   64'(bus_a.ch),   64'h0);
        check("reset_a_tick", 64'(bus_a.tick), 64'h0);
        check("reset_b_dout", 64'(bus_b.dout), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table on A (B parked in HOLD)
        for (int i = 0; i < 22; i++) begin
            drive_a(vecs[i].mode, vecs[i].en, vecs[i].sel, vecs[i].din, vecs[i].div);
            tick_cycle();
            check($sformatf("vec%0d_dout", i), 64'(bus_a.dout), vecs[i].exp_dout);
            check($sformatf("vec%0d_ch", i),   64'(bus_a.ch),   64'(vecs[i].exp_ch));
            check($sformatf("vec%0d_tick", i), 64'(bus_a.tick), 64'(vecs[i].exp_tick));
        end

        // B: sticky latch with DW=4, out-of-range select, SCAN with div=0
        drive_a(MODE_HOLD, 1'b0, 0, 0, 0);
        drive_b(MODE_LATCH, 1'b1, 3, 'hA, 0);
        tick_cycle();
        check("latch_w3", 64'(bus_b.dout), 64'h0000_A000);
        drive_b(MODE_LATCH, 1'b1, 7, 'h5, 0);
        tick_cycle();
        check("latch_w7", 64'(bus_b.dout), 64'h5000_A000);
        drive_b(MODE_LATCH, 1'b0, 3, 'hF, 0);
        tick_cycle();
        check("latch_en0", 64'(bus_b.dout), 64'h5000_A000);
        drive_b(MODE_LATCH, 1'b1, 12, 'hF, 0);
        tick_cycle();
        check("latch_oor", 64'(bus_b.dout), 64'h5000_A000);
        drive_b(MODE_DIRECT, 1'b1, 12, 'hF, 0);
        tick_cycle();
        check("direct_oor", 64'(bus_b.dout), 64'h0);
        drive_b(MODE_SCAN, 1'b1, 13, 'h9, 0);
        tick_cycle();
        check("scan_oor_ch",   64'(bus_b.ch),   64'd0);
        check("scan_oor_dout", 64'(bus_b.dout), 64'h9);
        check("scan_oor_tick", 64'(bus_b.tick), 64'h0);
        for (int i = 1; i <= 2; i++) begin
            tick_cycle();
            check($sformatf("div0_ch%0d", i),   64'(bus_b.ch),   64'(i));
            check($sformatf("div0_tick%0d", i), 64'(bus_b.tick), 64'h1);
            check($sformatf("div0_dout%0d", i), 64'(bus_b.dout), 64'h9 << (4 * i));
        end

        // A: divisor lowered below the running count
        drive_a(MODE_SCAN, 1'b1, 2, 1, 10);
        tick_cycle();
        check("lower_entry_ch", 64'(bus_a.ch), 64'd2);
        for (int i = 1; i <= 7; i++) begin
            tick_cycle();
            check($sformatf("lower_cnt%0d_tick", i), 64'(bus_a.tick), 64'h0);
        end
        drive_a(MODE_SCAN, 1'b1, 2, 1, 3);
        tick_cycle();
        check("lower_tick", 64'(bus_a.tick), 64'h1);
        check("lower_ch",   64'(bus_a.ch),   64'd3);
        check("lower_dout", 64'(bus_a.dout), 64'h0008);
        for (int i = 1; i <= 4; i++) begin
            tick_cycle();
            check($sformatf("lower_after%0d_tick", i), 64'(bus_a.tick), 64'(i == 4));
            check($sformatf("lower_after%0d_ch", i),   64'(bus_a.ch),   64'(i == 4 ? 4 : 3));
        end

        // A: asynchronous reset in the middle of a scan at ch=9
        drive_a(MODE_HOLD, 1'b1, 9, 1, 2);
        tick_cycle();
        drive_a(MODE_SCAN, 1'b1, 9, 1, 2);
        tick_cycle();
        check("midscan_ch", 64'(bus_a.ch), 64'd9);
        check("midscan_dout", 64'(bus_a.dout), 64'h0200);
        #2 rst_n = 1'b0;
        #1;
        check("async_a_dout", 64'(bus_a.dout), 64'h0);
        check("async_a_ch",   64'(bus_a.ch),   64'h0);
        check("async_a_tick", 64'(bus_a.tick), 64'h0);
        check("async_b_dout", 64'(bus_b.dout), 64'h0);
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick_cycle();
            check($sformatf("rel%0d_tick", i), 64'(bus_a.tick), 64'(i == 3));
            check($sformatf("rel%0d_ch", i),   64'(bus_a.ch),   64'(i == 3 ? 1 : 0));
            check($sformatf("rel%0d_dout", i), 64'(bus_a.dout), 64'(i == 3 ? 2 : 1));
        end

        // Random stimulus on both instances against the model
        begin
            mode_e ma, mb;
            int    da, db;
            ma = MODE_SCAN;
            mb = MODE_SCAN;
            da = 1;
            db = 0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 7) == 0) ma = mode_e'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) mb = mode_e'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) da = $urandom_range(0, 4);
                if ($urandom_range(0, 15) == 0) db = $urandom_range(0, 4);
                drive_a(ma, $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 1), da);
                drive_b(mb, $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15), db);
                tick_cycle();
                compare_model("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1_n_seq.md
DEMUX1_N_SEQ -- requirements
Module: demux1_n_seq

Interface
REQ-001 Parameter N_CH, default 16: number of output channels; legal range 2..64.
REQ-002 Parameter DW, default 1: data width per channel.
REQ-003 Parameter DIV_W, default 26: width of the scan prescaler divisor.
REQ-004 Derived constant SW_W = clog2(N_CH): select and channel-index width.
REQ-005 Clock and reset shall be: one clock, reset asynchronous and active-low.
REQ-006 clk  in  1  rising-edge system clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 en  in  1  enable; the low-level meaning depends on mode (see Function).
REQ-009 mode  in  2  00 DIRECT, 01 SCAN, 10 LATCH, 11 HOLD.
REQ-010 sel  in  SW_W  channel select for DIRECT and LATCH; scan start channel for SCAN.
REQ-011 din  in  DW  data to route.
REQ-012 div  in  DIV_W  scan period minus one, in clk cycles.
REQ-013 dout  out  N_CH*DW  channel k occupies bits [k*DW +: DW], registered.
REQ-014 ch  out  SW_W  currently active channel, registered.
REQ-015 tick  out  1  one-cycle pulse on each scan step, registered.

Function
REQ-016 All outputs shall be registered; latency from input to dout/ch shall be exactly 1 clk.
REQ-017 DIRECT mode, en=1: the next dout shall have din in channel sel and zero in all other channels; ch shall take the value of sel.
REQ-018 DIRECT or SCAN mode, en=0: the next dout shall be all zero; ch and the scan counters shall hold.
REQ-019 SCAN mode: the prescaler shall count 0..div; when it reaches div it shall clear to 0, pulse tick, and advance ch by one.
REQ-020 SCAN wrap: ch = N_CH-1 shall advance to 0.
REQ-021 SCAN mode: dout shall carry din in channel ch (the post-update value) and zero elsewhere; with div=0, ch shall advance every cycle.
REQ-022 Entering SCAN from any other mode: the prescaler shall clear, ch shall load sel, and tick shall be 0 on that cycle.
REQ-023 If div is lowered below the current prescaler count, the prescaler shall treat it as terminal count on the next cycle (clear, tick, advance).
REQ-024 SCAN with en=0: the prescaler shall freeze and tick shall stay 0.
REQ-025 LATCH mode, en=1: din shall be written into channel sel and all other channels shall hold (sticky register bank); en=0 shall hold all channels.
REQ-026 HOLD mode: dout and ch shall hold regardless of en; tick shall be 0.
REQ-027 sel >= N_CH (non-power-of-two N_CH): in DIRECT, dout shall go all zero; in LATCH, no write shall occur; in SCAN, ch shall load 0.
REQ-028 Switching from DIRECT or SCAN into LATCH shall keep the current dout as the initial latched contents.
REQ-029 tick shall be high only in SCAN with en=1.

Reset
REQ-030 While rst_n=0: dout, ch, tick and the prescaler shall all be 0, asynchronously.
REQ-031 Reset deasserted mid-scan: scanning shall restart from ch=0 with the prescaler at 0, and the first tick shall come after div+1 enabled cycles.

Structure
REQ-032 Package demux_pkg shall hold the mode encodings (MODE_DIRECT, MODE_SCAN, MODE_LATCH, MODE_HOLD) and the clog2 helper.
REQ-033 The prescaler shall be one sub-module, tick_prescaler (params DIV_W; ports clk, rst_n, run, clr, div, tick).
REQ-034 Channel decode and the dout register bank shall sit in demux1_n_seq.

Verification
REQ-035 N_CH=16, DW=1, DIRECT, en=1, sel=5, din=1 -> next cycle dout=0x0020, ch=5; then en=0 -> dout=0x0000.
REQ-036 SCAN, div=2, sel=14, din=1, en=1 -> ch=14 on entry; tick every 3rd cycle; ch goes 14,15,0,1; dout one-hot follows ch.
REQ-037 LATCH, DW=4: write sel=3 din=0xA, then sel=7 din=0x5 -> channels 3=0xA and 7=0x5 held; set en=0 and change din -> no change.
REQ-038 SCAN, div=10, count at 7, then div changed to 3 -> on the next cycle tick=1, prescaler=0, ch+1.
REQ-039 N_CH=10, DIRECT, sel=12 -> dout all zero; LATCH with sel=12 -> contents unchanged.
REQ-040 rst_n pulsed low mid-scan (ch=9) -> outputs 0 immediately without a clock; after release, first tick after div+1 cycles with ch 0 to 1.
